// File: rtl/rr_grant_ctrl_pkg.sv
// Shared definitions for the round-robin grant controller: FSM encoding and
// the pointer wrap helper.
package rr_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t GRANT   = 2'd1;
  localparam state_t RELEASE = 2'd2;

  // Next search start after serving index p among n requesters.
  function automatic int ptr_wrap(input int p, input int n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between requesters (master) and the grant controller
// (slave).
interface rr_grant_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
);
  logic [WIDTH-1:0] req;
  logic             ack;
  logic [WIDTH-1:0] grant;
  logic [IDXW-1:0]  grant_idx;
  logic             busy;
  logic [WIDTH-1:0] pending;
  logic             timeout;

  modport master (output req, ack,
                  input  grant, grant_idx, busy, pending, timeout);
  modport slave  (input  req, ack,
                  output grant, grant_idx, busy, pending, timeout);
endinterface

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first set bit of vec at or above ptr, wrapping
// from WIDTH-1 back to 0.
module rr_priority_pick #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [IDXW-1:0]  ptr,
  output logic [WIDTH-1:0] onehot,
  output logic [IDXW-1:0]  idx,
  output logic             any
);

  int              j;
  logic [IDXW-1:0] jj;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    jj     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      j = int'(ptr) + i;
      if (j >= WIDTH) j = j - WIDTH;
      jj = IDXW'(j);
      if (!any && vec[jj]) begin
        any        = 1'b1;
        onehot[jj] = 1'b1;
        idx        = jj;
      end
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: latches requests, grants one requester at a
// time until ack. Optional grant watchdog under RR_TIMEOUT_EN.
module rr_grant_ctrl
  import rr_arb_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int IDXW           = $clog2(WIDTH),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  rr_grant_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d, grant_q, grant_d;
  logic [WIDTH-1:0] vec, win_oh, clr;
  logic [IDXW-1:0]  ptr_q, ptr_d, idx_q, idx_d, win_idx;
  logic             win_any, expire, done;

  assign vec = pending_q | bus.req;

  rr_priority_pick #(.WIDTH(WIDTH), .IDXW(IDXW)) u_pick (
    .vec    (vec),
    .ptr    (ptr_q),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  // A watchdog expiry ends the grant exactly like an ack.
  assign done = (state_q == GRANT) && (bus.ack || expire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_any) state_d = GRANT;
      GRANT:   if (done)    state_d = RELEASE;
      RELEASE: state_d = win_any ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr       = done ? grant_q : '0;
    pending_d = vec & ~clr;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    if (state_q != GRANT) begin
      grant_d = win_any ? win_oh  : '0;
      idx_d   = win_any ? win_idx : '0;
    end else if (done) begin
      grant_d = '0;
      idx_d   = '0;
      ptr_d   = IDXW'(ptr_wrap(int'(idx_q), WIDTH));
    end
  end

`ifdef RR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Counter sits at zero outside GRANT, so every grant starts counting from 0.
  assign expire    = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d     = (state_q == GRANT) ? cnt_q + CW'(1) : '0;
  assign timeout_d = expire && !bus.ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = (state_q == GRANT);
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (WIDTH=4): reset, single grant, rotation,
// pointer wrap, re-request, and watchdog when RR_TIMEOUT_EN is defined.
module tb_rr_grant_ctrl;

`ifdef RR_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_grant_ctrl_if #(.WIDTH(4)) bus ();

  rr_grant_ctrl #(.WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expects grant g to be showing now; holds it, acks, checks the gap cycle.
  task automatic serve(input logic [3:0] g, input logic [1:0] gi, input int hold);
    chk("grant", 32'(bus.grant), 32'(g));
    chk("grant_idx", 32'(bus.grant_idx), 32'(gi));
    chk("busy", 32'(bus.busy), 32'd1);
    chk("timeout_idle", 32'(bus.timeout), 32'd0);
    repeat (hold) begin
      tick;
      chk("grant_hold", 32'(bus.grant), 32'(g));
    end
    bus.ack = 1'b1;
    tick;
    chk("grant_release", 32'(bus.grant), 32'd0);
    chk("busy_release", 32'(bus.busy), 32'd0);
    chk("idx_release", 32'(bus.grant_idx), 32'd0);
    bus.ack = 1'b0;
    tick;
  endtask

  initial begin
    bus.req = '0;
    bus.ack = 1'b0;
    repeat (2) tick;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_idx", 32'(bus.grant_idx), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    rst = 1'b1;
    tick;

    // Rotation with all requesters held; ack on the 2nd GRANT cycle.
    bus.req = 4'b1111;
    tick;
    serve(4'b0001, 2'd0, 1);
    serve(4'b0010, 2'd1, 1);
    serve(4'b0100, 2'd2, 1);
    serve(4'b1000, 2'd3, 1);
    bus.req = 4'b0000;
    chk("rot_pending", 32'(bus.pending), 32'hf);
    serve(4'b0001, 2'd0, 1);
    chk("rot_pending_clr", 32'(bus.pending), 32'he);
    serve(4'b0010, 2'd1, 0);
    serve(4'b0100, 2'd2, 0);
    serve(4'b1000, 2'd3, 0);
    chk("drain_grant", 32'(bus.grant), 32'd0);
    chk("drain_pending", 32'(bus.pending), 32'd0);

    // Single request: grant one cycle after req, ack after 3 GRANT cycles.
    bus.req = 4'b0010;
    tick;
    bus.req = 4'b0000;
    chk("single_pending", 32'(bus.pending), 32'h2);
    serve(4'b0010, 2'd1, 2);
    chk("single_pending_clr", 32'(bus.pending), 32'd0);
    chk("single_idle", 32'(bus.grant), 32'd0);

    // Pointer wrap: serve idx 2, then 0101 from ptr=3 wraps to 0 first.
    bus.req = 4'b0100;
    tick;
    bus.req = 4'b0000;
    serve(4'b0100, 2'd2, 0);
    chk("wrap_idle", 32'(bus.grant), 32'd0);
    bus.req = 4'b0101;
    tick;
    bus.req = 4'b0000;
    chk("wrap_pending", 32'(bus.pending), 32'h5);
    serve(4'b0001, 2'd0, 0);
    serve(4'b0100, 2'd2, 0);
    chk("wrap_done", 32'(bus.grant), 32'd0);

    // Ack while idle is ignored (ptr stays 3).
    bus.ack = 1'b1;
    tick;
    chk("idle_ack_grant", 32'(bus.grant), 32'd0);
    chk("idle_ack_busy", 32'(bus.busy), 32'd0);
    chk("idle_ack_pending", 32'(bus.pending), 32'd0);
    bus.ack = 1'b0;
    tick;

    // Granted requester re-requests on its own ack edge.
    bus.req = 4'b0011;
    tick;
    bus.req = 4'b0000;
    chk("rereq_grant", 32'(bus.grant), 32'h1);
    tick;
    bus.ack = 1'b1;
    bus.req = 4'b0001;
    tick;
    chk("rereq_rel", 32'(bus.grant), 32'd0);
    chk("rereq_clr_wins", 32'(bus.pending), 32'h2);
    bus.ack = 1'b0;
    tick;
    bus.req = 4'b0000;
    chk("rereq_relatch", 32'(bus.pending), 32'h3);
    serve(4'b0010, 2'd1, 0);
    serve(4'b0001, 2'd0, 0);
    chk("rereq_idle", 32'(bus.grant), 32'd0);

    // Asynchronous reset in the middle of a grant.
    bus.req = 4'b0100;
    tick;
    bus.req = 4'b0000;
    chk("pre_rst_grant", 32'(bus.grant), 32'h4);
    #2 rst = 1'b0;
    #1;
    chk("async_grant", 32'(bus.grant), 32'd0);
    chk("async_idx", 32'(bus.grant_idx), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_pending", 32'(bus.pending), 32'd0);
    tick;
    rst = 1'b1;
    tick;
    tick;
    chk("post_rst_idle", 32'(bus.grant), 32'd0);
    chk("post_rst_pending", 32'(bus.pending), 32'd0);
    bus.req = 4'b1111;
    tick;
    bus.req = 4'b0000;
    chk("post_rst_ptr", 32'(bus.grant), 32'h1);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("rst2_idle", 32'(bus.grant), 32'd0);

`ifdef RR_TIMEOUT_EN
    bus.req = 4'b1000;
    tick;
    bus.req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      chk("to_hold", 32'(bus.grant), 32'h8);
      chk("to_nopulse", 32'(bus.timeout), 32'd0);
      tick;
    end
    chk("to_hold_last", 32'(bus.grant), 32'h8);
    tick;
    chk("to_drop", 32'(bus.grant), 32'd0);
    chk("to_pulse", 32'(bus.timeout), 32'd1);
    chk("to_pending", 32'(bus.pending), 32'd0);
    tick;
    chk("to_pulse_end", 32'(bus.timeout), 32'd0);
    bus.req = 4'b1000;
    tick;
    bus.req = 4'b0000;
    repeat (3) tick;
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    chk("coll_drop", 32'(bus.grant), 32'd0);
    chk("coll_nopulse", 32'(bus.timeout), 32'd0);
    tick;
    chk("coll_nopulse2", 32'(bus.timeout), 32'd0);
`else
    bus.req = 4'b1000;
    tick;
    bus.req = 4'b0000;
    repeat (20) tick;
    chk("no_to_hold", 32'(bus.grant), 32'h8);
    chk("no_to_pulse", 32'(bus.timeout), 32'd0);
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    chk("no_to_rel", 32'(bus.grant), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
